// File: rtl/noise_pkg.sv
// Shared definitions for the window impulse-noise checker: default sizing,
// derived window geometry and the controller state encoding.
package noise_pkg;

  localparam int ADDR_WIDTH_DEF = 8;
  localparam int PIX_WIDTH_DEF  = 8;
  localparam int WINDOW_N_DEF   = 2;
  localparam int THRESH_DEF     = 40;

  localparam int K          = 2*WINDOW_N_DEF + 1;
  localparam int NUM_TAPS   = K*K;
  localparam int CENTER_TAP = (NUM_TAPS - 1) / 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_t;

  // Number of taps in a square window of the given half-width.
  function automatic int taps_for(input int half_width);
    return (2*half_width + 1) * (2*half_width + 1);
  endfunction

  // Index of the middle tap when the window is walked row-major.
  function automatic int center_tap_for(input int half_width);
    return (taps_for(half_width) - 1) / 2;
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Row-major address walker for a KxK window: steps +1 along a row and jumps
// to the start of the next row at the row end. Addresses wrap modulo
// 2^ADDR_WIDTH; the producer guarantees the window lies inside the image.
module window_addr_gen
  import noise_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int WINDOW_N   = WINDOW_N_DEF
)(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic                  i_advance,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [15:0]           i_N,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_last_tap
);

  localparam int KW = 2*WINDOW_N + 1;
  localparam int CW = $clog2(KW + 1);
  localparam logic [CW-1:0] KM1 = CW'(KW - 1);

  logic [CW-1:0]         r_col;
  logic [CW-1:0]         r_row;
  logic [15:0]           r_N;
  logic [ADDR_WIDTH-1:0] w_row_step;

  // Jump from the last column of one row to the first column of the next.
  assign w_row_step = ADDR_WIDTH'(32'(r_N) - 32'(KW - 1));
  assign o_last_tap = (r_row == KM1) && (r_col == KM1);

  // Counter and address register: load restarts the walk at base and
  // freezes the row width for the whole window.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_N        <= '0;
      o_mem_addr <= '0;
    end else if (i_load) begin
      r_col      <= '0;
      r_row      <= '0;
      r_N        <= i_N;
      o_mem_addr <= i_base;
    end else if (i_advance) begin
      if (r_col == KM1) begin
        r_col      <= '0;
        r_row      <= r_row + 1'b1;
        o_mem_addr <= o_mem_addr + w_row_step;
      end else begin
        r_col      <= r_col + 1'b1;
        o_mem_addr <= o_mem_addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/window_noise_check.sv
// Impulse-noise check on one window: fetches every tap of the window around
// a centre address, tracks min/max, captures the centre pixel and flags the
// centre as noise when it is an extreme of a wide-enough window.
module window_noise_check
  import noise_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int WINDOW_N   = WINDOW_N_DEF,
  parameter int PIX_WIDTH  = PIX_WIDTH_DEF,
  parameter int THRESH     = THRESH_DEF
)(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_addr_c,
  input  logic [15:0]           i_N,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_rd,
  input  logic [PIX_WIDTH-1:0]  i_mem_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_noise,
  output logic [PIX_WIDTH-1:0]  o_center_pix
);

  localparam int TAPS    = taps_for(WINDOW_N);
  localparam int CTR_TAP = center_tap_for(WINDOW_N);
  localparam int TW      = $clog2(TAPS + 1);

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_start_accept;
  logic                  w_last_tap;
  logic                  w_advance;
  logic [ADDR_WIDTH-1:0] w_base;

  logic                  r_data_valid;
  logic [TW-1:0]         r_tap_idx;
  logic [PIX_WIDTH-1:0]  r_min;
  logic [PIX_WIDTH-1:0]  r_max;
  logic [PIX_WIDTH-1:0]  w_min_fin;
  logic [PIX_WIDTH-1:0]  w_max_fin;
  logic [PIX_WIDTH-1:0]  w_center_fin;
  logic [PIX_WIDTH-1:0]  w_range;
  logic                  w_noise;

  // A new window may begin while idle or in the single done cycle.
  assign w_start_accept = i_start && ((r_state == IDLE) || (r_state == REPORT));
  assign w_advance      = (r_state == FETCH) && !w_last_tap;
  assign w_base         = i_addr_c - ADDR_WIDTH'(32'(WINDOW_N) * 32'(i_N))
                                   - ADDR_WIDTH'(WINDOW_N);

  window_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WINDOW_N   (WINDOW_N)
  ) u_addr_gen (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_start_accept),
    .i_advance  (w_advance),
    .i_base     (w_base),
    .i_N        (i_N),
    .o_mem_addr (o_mem_addr),
    .o_last_tap (w_last_tap)
  );

  // Controller state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode: fetch all taps, absorb the final read, report once.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (i_start) w_state_next = FETCH;
      FETCH:   if (w_last_tap) w_state_next = DRAIN;
      DRAIN:   w_state_next = REPORT;
      REPORT:  w_state_next = i_start ? FETCH : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Strobes are registered from the upcoming state so they line up with it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_mem_rd <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_mem_rd <= (w_state_next == FETCH);
      o_busy   <= (w_state_next == FETCH) || (w_state_next == DRAIN);
      o_done   <= (w_state_next == REPORT);
    end
  end

  // Fold the tap arriving this cycle into min/max/centre and form the verdict.
  always_comb begin
    w_min_fin    = r_min;
    w_max_fin    = r_max;
    w_center_fin = o_center_pix;
    if (r_data_valid) begin
      if (i_mem_data <= r_min) w_min_fin = i_mem_data;
      if (i_mem_data >= r_max) w_max_fin = i_mem_data;
      if (r_tap_idx == TW'(CTR_TAP)) w_center_fin = i_mem_data;
    end
    w_range = w_max_fin - w_min_fin;
    w_noise = ((w_center_fin == w_min_fin) || (w_center_fin == w_max_fin))
              && (w_range > PIX_WIDTH'(THRESH));
  end

  // Statistics registers: cleared on each accepted start, updated per tap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data_valid <= 1'b0;
      r_tap_idx    <= '0;
      r_min        <= '1;
      r_max        <= '0;
      o_center_pix <= '0;
    end else begin
      r_data_valid <= o_mem_rd;
      if (w_start_accept) begin
        r_tap_idx <= '0;
        r_min     <= '1;
        r_max     <= '0;
      end else if (r_data_valid) begin
        r_tap_idx    <= r_tap_idx + 1'b1;
        r_min        <= w_min_fin;
        r_max        <= w_max_fin;
        o_center_pix <= w_center_fin;
      end
    end
  end

  // The verdict is latched as the last tap is absorbed and held until reused.
  always_ff @(posedge i_clk) begin
    if (i_rst)                  o_noise <= 1'b0;
    else if (r_state == DRAIN)  o_noise <= w_noise;
  end

endmodule

// File: tb/tb_window_noise_check.sv
// Randomized self-checking bench for window_noise_check with a behavioural
// RAM and a window reference model built from the decision rule.
module tb_window_noise_check;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  addr_c;
  logic [15:0] N;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        busy;
  logic        done;
  logic        noise;
  logic [7:0]  center_pix;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] mem [256];

  logic [7:0] obs_addr[$];
  logic [7:0] exp_addr[$];
  int         lat, rd_first, rd_last, busy_bad;
  logic       done_seen, obs_noise, exp_noise;
  logic [7:0] obs_center, exp_center;
  logic       post_busy, post_rd, post_done;

  // Free-running clock.
  always #5 clk = ~clk;

  // Single-cycle-latency image RAM.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  window_noise_check dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_addr_c     (addr_c),
    .i_N          (N),
    .o_mem_addr   (mem_addr),
    .o_mem_rd     (mem_rd),
    .i_mem_data   (mem_data),
    .o_busy       (busy),
    .o_done       (done),
    .o_noise      (noise),
    .o_center_pix (center_pix)
  );

  function automatic logic [7:0] tap_addr(input logic [7:0] a, input logic [15:0] n,
                                          input int r, input int c);
    int v;
    v = int'(a) + (r - 2) * int'(n) + (c - 2);
    return 8'(v);
  endfunction

  // Reference: list the window addresses and apply the noise rule directly.
  task automatic model_window(input logic [7:0] a, input logic [15:0] n);
    int mn, mx, ctr;
    exp_addr.delete();
    mn = 255;
    mx = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        exp_addr.push_back(tap_addr(a, n, r, c));
        if (int'(mem[tap_addr(a, n, r, c)]) < mn) mn = int'(mem[tap_addr(a, n, r, c)]);
        if (int'(mem[tap_addr(a, n, r, c)]) > mx) mx = int'(mem[tap_addr(a, n, r, c)]);
      end
    ctr        = int'(mem[tap_addr(a, n, 2, 2)]);
    exp_center = 8'(ctr);
    exp_noise  = ((ctr == mn) || (ctr == mx)) && ((mx - mn) > 40);
  endtask

  // Patterns: 0 flat, 1 salt, 2 pepper, 3 sub-threshold, 4 gradient.
  task automatic fill_pattern(input logic [7:0] a, input logic [15:0] n, input int kind);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        if (kind == 4)      mem[tap_addr(a, n, r, c)] = 8'(60 + 20 * c);
        else                mem[tap_addr(a, n, r, c)] = 8'd100;
      end
    case (kind)
      1: mem[tap_addr(a, n, 2, 2)] = 8'd255;
      2: mem[tap_addr(a, n, 2, 2)] = 8'd0;
      3: mem[tap_addr(a, n, 2, 2)] = 8'd130;
      default: ;
    endcase
  endtask

  // Drive one window and record what the DUT does; N is disturbed mid-flight.
  task automatic run_window(input logic [7:0] a, input logic [15:0] n, input int stray,
                            input int rst_at, input bit pre_started, input bit chain,
                            input logic [7:0] ca, input logic [15:0] cn);
    obs_addr.delete();
    lat = 0; rd_first = 0; rd_last = 0; busy_bad = 0; done_seen = 1'b0;
    if (!pre_started) begin
      @(negedge clk);
      start  = 1'b1;
      addr_c = a;
      N      = n;
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 2) N = 16'(N + 16'd7);
      if (rst_at != 0 && c == rst_at + 1) begin
        post_busy = busy; post_rd = mem_rd; post_done = done;
        rst = 1'b0;
      end
      if (done) done_seen = 1'b1;
      if (mem_rd) begin
        obs_addr.push_back(mem_addr);
        if (rd_first == 0) rd_first = c;
        rd_last = c;
      end
      if ((rst_at == 0 || c <= rst_at) && busy !== (c <= 26)) busy_bad++;
      if (c == stray) begin
        start  = 1'b1;
        addr_c = 8'(a + 8'd50);
      end
      if (rst_at != 0 && c == rst_at) rst = 1'b1;
      if (done && rst_at == 0) begin
        lat = c; obs_noise = noise; obs_center = center_pix;
        if (chain) begin
          start = 1'b1; addr_c = ca; N = cn;
        end
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; addr_c = '0; N = '0;
    repeat (3) @(negedge clk);
    vectors += 6;
    if (mem_addr !== 8'd0)   begin miscompares++; $display("[TB] FAIL reset_mem_addr got %0d want 0", mem_addr); end
    if (mem_rd !== 1'b0)     begin miscompares++; $display("[TB] FAIL reset_mem_rd got %0b want 0", mem_rd); end
    if (busy !== 1'b0)       begin miscompares++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
    if (done !== 1'b0)       begin miscompares++; $display("[TB] FAIL reset_done got %0b want 0", done); end
    if (noise !== 1'b0)      begin miscompares++; $display("[TB] FAIL reset_noise got %0b want 0", noise); end
    if (center_pix !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_center got %0d want 0", center_pix); end
    rst = 1'b0;
  endtask

  task automatic test_addr_walk;
    logic [7:0] want[$];
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) want.push_back(8'(r * 10 + c));
    run_window(8'd22, 16'd10, 0, 0, 1'b0, 1'b0, 8'd0, 16'd0);
    vectors += 5;
    if (lat !== 27)               begin miscompares++; $display("[TB] FAIL walk_latency got %0d want 27", lat); end
    if (obs_addr.size() !== 25)   begin miscompares++; $display("[TB] FAIL walk_count got %0d want 25", obs_addr.size()); end
    if (rd_first !== 1)           begin miscompares++; $display("[TB] FAIL walk_rd_first got %0d want 1", rd_first); end
    if (rd_last !== 25)           begin miscompares++; $display("[TB] FAIL walk_rd_last got %0d want 25", rd_last); end
    if (busy_bad !== 0)           begin miscompares++; $display("[TB] FAIL walk_busy bad_cycles %0d want 0", busy_bad); end
    for (int i = 0; i < 25 && i < obs_addr.size(); i++) begin
      vectors++;
      if (obs_addr[i] !== want[i]) begin
        miscompares++;
        $display("[TB] FAIL walk_addr[%0d] got %0d want %0d", i, obs_addr[i], want[i]);
      end
    end
  endtask

  task automatic test_patterns;
    logic       want_noise [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] want_ctr   [5] = '{8'd100, 8'd255, 8'd0, 8'd130, 8'd100};
    for (int k = 0; k < 5; k++) begin
      fill_pattern(8'd60, 16'd12, k);
      run_window(8'd60, 16'd12, 0, 0, 1'b0, 1'b0, 8'd0, 16'd0);
      vectors += 4;
      if (lat !== 27)                 begin miscompares++; $display("[TB] FAIL pattern%0d_latency got %0d want 27", k, lat); end
      if (busy_bad !== 0)             begin miscompares++; $display("[TB] FAIL pattern%0d_busy bad_cycles %0d", k, busy_bad); end
      if (obs_noise !== want_noise[k]) begin miscompares++; $display("[TB] FAIL pattern%0d_noise got %0b want %0b", k, obs_noise, want_noise[k]); end
      if (obs_center !== want_ctr[k])  begin miscompares++; $display("[TB] FAIL pattern%0d_center got %0d want %0d", k, obs_center, want_ctr[k]); end
    end
  endtask

  task automatic test_random;
    logic [7:0]  a;
    logic [15:0] n;
    int          lo, span;
    for (int t = 0; t < 16; t++) begin
      a = 8'($urandom); n = 16'($urandom_range(5, 40));
      lo = $urandom_range(0, 200); span = $urandom_range(0, 55);
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) mem[tap_addr(a, n, r, c)] = 8'(lo + $urandom_range(0, span));
      if ($urandom_range(0, 1) == 1)
        mem[tap_addr(a, n, 2, 2)] = ($urandom_range(0, 1) == 1) ? 8'(lo + span) : 8'(lo);
      model_window(a, n);
      run_window(a, n, 0, 0, 1'b0, 1'b0, 8'd0, 16'd0);
      vectors += 4;
      if (lat !== 27)               begin miscompares++; $display("[TB] FAIL rand%0d_latency got %0d want 27", t, lat); end
      if (obs_noise !== exp_noise)   begin miscompares++; $display("[TB] FAIL rand%0d_noise got %0b want %0b", t, obs_noise, exp_noise); end
      if (obs_center !== exp_center) begin miscompares++; $display("[TB] FAIL rand%0d_center got %0d want %0d", t, obs_center, exp_center); end
      if (obs_addr.size() !== 25)    begin miscompares++; $display("[TB] FAIL rand%0d_count got %0d want 25", t, obs_addr.size()); end
      for (int i = 0; i < 25 && i < obs_addr.size(); i++) begin
        vectors++;
        if (obs_addr[i] !== exp_addr[i]) begin
          miscompares++;
          $display("[TB] FAIL rand%0d_addr[%0d] got %0d want %0d", t, i, obs_addr[i], exp_addr[i]);
        end
      end
    end
  endtask

  task automatic test_start_ignored;
    fill_pattern(8'd60, 16'd12, 1);
    model_window(8'd60, 16'd12);
    run_window(8'd60, 16'd12, 5, 0, 1'b0, 1'b0, 8'd0, 16'd0);
    vectors += 3;
    if (lat !== 27)              begin miscompares++; $display("[TB] FAIL stray_latency got %0d want 27", lat); end
    if (obs_noise !== exp_noise) begin miscompares++; $display("[TB] FAIL stray_noise got %0b want %0b", obs_noise, exp_noise); end
    if (obs_addr.size() !== 25)  begin miscompares++; $display("[TB] FAIL stray_count got %0d want 25", obs_addr.size()); end
    for (int i = 0; i < 25 && i < obs_addr.size(); i++) begin
      vectors++;
      if (obs_addr[i] !== exp_addr[i]) begin
        miscompares++;
        $display("[TB] FAIL stray_addr[%0d] got %0d want %0d", i, obs_addr[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    fill_pattern(8'd60, 16'd12, 2);
    run_window(8'd60, 16'd12, 0, 10, 1'b0, 1'b0, 8'd0, 16'd0);
    vectors += 5;
    if (post_busy !== 1'b0)   begin miscompares++; $display("[TB] FAIL abort_busy got %0b want 0", post_busy); end
    if (post_rd !== 1'b0)     begin miscompares++; $display("[TB] FAIL abort_mem_rd got %0b want 0", post_rd); end
    if (post_done !== 1'b0)   begin miscompares++; $display("[TB] FAIL abort_done got %0b want 0", post_done); end
    if (done_seen !== 1'b0)   begin miscompares++; $display("[TB] FAIL abort_no_done got %0b want 0", done_seen); end
    if (rd_last !== 10)       begin miscompares++; $display("[TB] FAIL abort_last_read got %0d want 10", rd_last); end
    run_window(8'd60, 16'd12, 0, 0, 1'b0, 1'b0, 8'd0, 16'd0);
    vectors += 3;
    if (lat !== 27)              begin miscompares++; $display("[TB] FAIL restart_latency got %0d want 27", lat); end
    if (obs_noise !== 1'b1)      begin miscompares++; $display("[TB] FAIL restart_noise got %0b want 1", obs_noise); end
    if (obs_center !== 8'd0)     begin miscompares++; $display("[TB] FAIL restart_center got %0d want 0", obs_center); end
  endtask

  task automatic test_back_to_back;
    fill_pattern(8'd60, 16'd12, 0);
    fill_pattern(8'd200, 16'd8, 1);
    run_window(8'd60, 16'd12, 0, 0, 1'b0, 1'b1, 8'd200, 16'd8);
    vectors += 2;
    if (lat !== 27)          begin miscompares++; $display("[TB] FAIL b2b_first_latency got %0d want 27", lat); end
    if (obs_noise !== 1'b0)  begin miscompares++; $display("[TB] FAIL b2b_first_noise got %0b want 0", obs_noise); end
    model_window(8'd200, 16'd8);
    run_window(8'd200, 16'd8, 0, 0, 1'b1, 1'b0, 8'd0, 16'd0);
    vectors += 4;
    if (lat !== 27)               begin miscompares++; $display("[TB] FAIL b2b_second_latency got %0d want 27", lat); end
    if (obs_noise !== 1'b1)       begin miscompares++; $display("[TB] FAIL b2b_second_noise got %0b want 1", obs_noise); end
    if (obs_center !== 8'd255)    begin miscompares++; $display("[TB] FAIL b2b_second_center got %0d want 255", obs_center); end
    if (obs_addr.size() !== 25 || obs_addr[0] !== exp_addr[0]) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_walk count %0d first %0d want 25 and %0d",
               obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : 8'hxx, exp_addr[0]);
    end
  endtask

  // Run the scenarios in order and report.
  initial begin
    test_reset;
    test_addr_walk;
    test_patterns;
    test_start_ignored;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/window_noise_check.md
Name: window_noise_check

Overview:
Downstream consumer of the window-centre address stream produced by the pixel slider.
- For each centre address it fetches the full (2*WINDOW_N+1)^2 neighbourhood from the image RAM, one pixel per cycle.
- It tracks the window min and max and captures the centre pixel.
- It flags the centre as impulse noise if the centre is an extreme of the window and the window range exceeds a threshold.

Parameters:
ADDR_WIDTH, 8, image RAM address width (matches slider addrP)
WINDOW_N, 2, window half-width; K = 2*WINDOW_N+1 taps per side
PIX_WIDTH, 8, pixel width
THRESH, 40, minimum (max-min) range required to declare noise

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; latches addr_c; ignored unless IDLE
addr_c  in  ADDR_WIDTH  window centre address (slider addrP)
N  in  16  image row width in pixels
mem_addr  out  ADDR_WIDTH  RAM read address (registered)
mem_rd  out  1  RAM read strobe (registered)
mem_data  in  PIX_WIDTH  RAM read data, valid exactly 1 cycle after mem_rd
busy  out  1  high from first read issue until done
done  out  1  one-cycle pulse; noise/center_pix valid from this cycle until next start
noise  out  1  noise decision for last window
center_pix  out  PIX_WIDTH  centre pixel value of last window

Behaviour:
- Reset: the block enters IDLE, and every output is cleared: mem_addr, mem_rd, busy, done, noise and center_pix are all 0. Internal min is set to all-ones and max to 0.
- States: IDLE -> FETCH -> DRAIN -> REPORT -> IDLE.
- IDLE -> FETCH: on a clock edge T with start=1:
  - Latch addr_c and N.
  - Initial address base = addr_c - WINDOW_N*N - WINDOW_N.
  - Reset min/max and the tap counters.
- FETCH, cycles T+1 .. T+K*K:
  - mem_rd=1 and busy=1.
  - mem_addr walks row-major: +1 within a row; at row end (column counter = K-1), add N-(K-1).
  - Address arithmetic is done at 17+ bits, then truncated to ADDR_WIDTH, i.e. wraps modulo 2^ADDR_WIDTH. No bounds check is made; the slider guarantees the window is in range.
- Data path: mem_data returning in the cycle after each read updates min/max using inclusive compares. The tap whose index is (K*K-1)/2 (index 12 for WINDOW_N=2) is captured into center_pix.
- DRAIN, cycle T+K*K+1: mem_rd=0, busy=1. The final tap's data is absorbed.
- REPORT, cycle T+K*K+2:
  - done=1 and busy=0.
  - noise = ((center==min) || (center==max)) && ((max-min) > THRESH). The compare is unsigned and the range is PIX_WIDTH wide.
- Total latency: start edge to done = K*K+2 cycles (27 for WINDOW_N=2). Next start is accepted in the same cycle done is high, or later.
- start while not IDLE: ignored. It does not queue and does not restart.
- Flat window (min==max): range is 0, so noise=0.
- Ties: a centre equal to min or max counts as extreme even when other taps share that value.
- rst asserted mid-operation: the next edge returns to IDLE with all outputs 0. No done is produced for the aborted window.
- N is only sampled at start. Later changes to N do not affect the window in flight.

Decomposition:
- Shared package `noise_pkg`:
  - localparam K = 2*WINDOW_N+1
  - NUM_TAPS = K*K
  - CENTER_TAP = (NUM_TAPS-1)/2
  - state enum {IDLE, FETCH, DRAIN, REPORT}
  - PIX_WIDTH/ADDR_WIDTH defaults
- One sub-module, `window_addr_gen`: the row/column counters and incremental address walk. Interface: load, base, N in; mem_addr, last_tap out.
- The compare/decision logic stays in the top module.

Test Plan:
- Address walk: N=10, addr_c=22, WINDOW_N=2. mem_addr sequence must be 0-4, 10-14, 20-24, 30-34, 40-44 over 25 consecutive cycles, with mem_rd high exactly those cycles.
- Flat window, all pixels 100: done at T+27, noise=0, center_pix=100, busy high T+1..T+26.
- Salt impulse, centre 255 and others 100: noise=1, center_pix=255.
- Pepper impulse, centre 0 and others 100: noise=1.
- Sub-threshold and non-extreme cases:
  - centre 130, others 100 (range 30 <= 40): noise=0.
  - horizontal gradient 60..140 with centre at middle value 100: noise=0.
- Control:
  - start pulsed at read 5 is ignored, and the sequence is unchanged.
  - rst asserted at read 10: next cycle busy=0 and mem_rd=0, with no done.
  - a fresh start afterwards completes normally in 27 cycles.
  - back-to-back start coincident with done is accepted.
